// File: rtl/stopwatch_dp.sv
// Stopwatch time base: divides clk down to a hundredths tick and runs cascaded
// msec/sec/min/hour counters under a STOP/RUN/CLEAR controller with time-set load.
module stopwatch_dp #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_stop,
    input  logic       clear,
    input  logic       load,
    input  logic [5:0] set_sec,
    input  logic [5:0] set_min,
    input  logic [4:0] set_hour,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       running,
    output logic       tick
);

    localparam int unsigned DivN = CLK_FREQ / TICK_HZ;
    localparam int unsigned DivW = (DivN > 1) ? $clog2(DivN) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(DivN - 1);

    typedef enum logic [1:0] {StStop, StRun, StClear} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [6:0]      msec_q, msec_d;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [4:0]      hour_q, hour_d;
    logic            load_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StStop: begin
                if (clear) begin
                    state_d = StClear;
                end else if (load) begin
                    state_d = StStop;
                end else if (run_stop) begin
                    state_d = StRun;
                end
            end
            StRun:   if (run_stop) state_d = StStop;
            StClear: state_d = StStop;
            default: state_d = StStop;
        endcase
    end

    // Decoded from registers only, so the FND side sees no input-to-output path.
    always_comb begin
        running = (state_q == StRun);
        tick    = (state_q == StRun) && (div_q == DivMax);
    end

    assign load_ok = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23);

    always_comb begin
        div_d  = div_q;
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        case (state_q)
            StClear: begin
                div_d  = '0;
                msec_d = '0;
                sec_d  = '0;
                min_d  = '0;
                hour_d = '0;
            end
            StStop: begin
                if (!clear && load && load_ok) begin
                    div_d  = '0;
                    msec_d = '0;
                    sec_d  = set_sec;
                    min_d  = set_min;
                    hour_d = set_hour;
                end
            end
            StRun: begin
                if (tick) begin
                    div_d = '0;
                    if (msec_q == 7'd99) begin
                        msec_d = '0;
                        if (sec_q == 6'd59) begin
                            sec_d = '0;
                            if (min_q == 6'd59) begin
                                min_d  = '0;
                                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                            end else begin
                                min_d = min_q + 6'd1;
                            end
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        msec_d = msec_q + 7'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            div_q  <= div_d;
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

    assign msec = msec_q;
    assign sec  = sec_q;
    assign min  = min_q;
    assign hour = hour_q;

endmodule

// File: tb/tb_stopwatch_dp.sv
// Directed bench for stopwatch_dp with N = 10 (CLK_FREQ=1000, TICK_HZ=100).
module tb_stopwatch_dp;

    logic       clk;
    logic       reset;
    logic       run_stop;
    logic       clear;
    logic       load;
    logic [5:0] set_sec;
    logic [5:0] set_min;
    logic [4:0] set_hour;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       running;
    logic       tick;

    int n_vec;
    int n_err;
    int ticks;

    stopwatch_dp #(
        .CLK_FREQ(1000),
        .TICK_HZ (100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run_stop(run_stop),
        .clear   (clear),
        .load    (load),
        .set_sec (set_sec),
        .set_min (set_min),
        .set_hour(set_hour),
        .msec    (msec),
        .sec     (sec),
        .min     (min),
        .hour    (hour),
        .running (running),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge; exactly one rising edge samples the pulse.
    task automatic pulse(input logic rs, input logic cl, input logic ld);
        run_stop = rs;
        clear    = cl;
        load     = ld;
        @(negedge clk);
        run_stop = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
    endtask

    task automatic run_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
        end
    endtask

    task automatic set_vals(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
        set_sec  = s;
        set_min  = m;
        set_hour = h;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        ticks    = 0;
        reset    = 1'b1;
        run_stop = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        set_vals(6'd0, 6'd0, 5'd0);
        repeat (2) @(negedge clk);
        check("rst_msec", msec, 0);
        check("rst_sec", sec, 0);
        check("rst_min", min, 0);
        check("rst_hour", hour, 0);
        check("rst_running", running, 0);
        check("rst_tick", tick, 0);
        reset = 1'b0;

        // First tick exactly N clocks after run_stop, then a full second.
        pulse(1, 0, 0);
        check("run_running", running, 1);
        ticks = 0;
        run_clks(9);
        check("run_msec_9clk", msec, 0);
        run_clks(1);
        check("run_msec_10clk", msec, 1);
        check("run_one_tick", ticks, 1);
        run_clks(990);
        check("run_1s_msec", msec, 0);
        check("run_1s_sec", sec, 1);

        // Reach 00:00:03.07, then asynchronous reset mid-RUN.
        run_clks(2070);
        check("pre_rst_sec", sec, 3);
        check("pre_rst_msec", msec, 7);
        reset = 1'b1;
        #1;
        check("midrun_rst_msec", msec, 0);
        check("midrun_rst_sec", sec, 0);
        check("midrun_rst_running", running, 0);
        check("midrun_rst_tick", tick, 0);
        @(negedge clk);
        reset = 1'b0;

        // Pause keeps the fractional period: 25 clocks, stop (div 6), resume.
        pulse(1, 0, 0);
        run_clks(25);
        check("pause_msec", msec, 2);
        pulse(1, 0, 0);
        check("pause_running", running, 0);
        run_clks(100);
        check("idle_msec", msec, 2);
        pulse(1, 0, 0);
        run_clks(3);
        check("resume_3clk_msec", msec, 2);
        run_clks(2);
        check("resume_5clk_msec", msec, 3);

        // Clear ignored in RUN, honoured in STOP with two-edge latency.
        run_clks(9);
        check("at4_msec", msec, 4);
        pulse(0, 1, 0);
        check("clr_in_run_msec", msec, 4);
        check("clr_in_run_running", running, 1);
        run_clks(9);
        check("clr_in_run_cont", msec, 5);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("clr_1edge_msec", msec, 5);
        check("clr_1edge_running", running, 0);
        @(negedge clk);
        check("clr_2edge_msec", msec, 0);
        check("clr_2edge_running", running, 0);
        // Divider was cleared too: first tick after exactly N clocks.
        pulse(1, 0, 0);
        run_clks(9);
        check("postclr_9clk", msec, 0);
        run_clks(1);
        check("postclr_10clk", msec, 1);
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        check("clr_rs_running", running, 0);
        @(negedge clk);
        check("clr_rs_msec", msec, 0);
        run_clks(20);
        check("clr_rs_stays_msec", msec, 0);
        check("clr_rs_stays_running", running, 0);

        // Load 23:59:59.00 and run through the full wrap.
        set_vals(6'd59, 6'd59, 5'd23);
        pulse(0, 0, 1);
        check("load_sec", sec, 59);
        check("load_min", min, 59);
        check("load_hour", hour, 23);
        check("load_msec", msec, 0);
        pulse(1, 0, 0);
        run_clks(990);
        check("prewrap_msec", msec, 99);
        check("prewrap_hour", hour, 23);
        run_clks(10);
        check("wrap_msec", msec, 0);
        check("wrap_sec", sec, 0);
        check("wrap_min", min, 0);
        check("wrap_hour", hour, 0);

        // Out-of-range loads, load in RUN, load with run_stop.
        pulse(1, 0, 0);
        set_vals(6'd10, 6'd60, 5'd5);
        pulse(0, 0, 1);
        check("badmin_sec", sec, 0);
        check("badmin_min", min, 0);
        set_vals(6'd10, 6'd20, 5'd24);
        pulse(0, 0, 1);
        check("badhour_hour", hour, 0);
        check("badhour_sec", sec, 0);
        pulse(1, 0, 0);
        set_vals(6'd10, 6'd20, 5'd5);
        pulse(0, 0, 1);
        check("runload_sec", sec, 0);
        check("runload_running", running, 1);
        pulse(1, 0, 0);
        set_vals(6'd12, 6'd34, 5'd5);
        pulse(1, 0, 1);
        check("loadrs_sec", sec, 12);
        check("loadrs_min", min, 34);
        check("loadrs_hour", hour, 5);
        check("loadrs_msec", msec, 0);
        check("loadrs_running", running, 0);
        run_clks(20);
        check("loadrs_stays_msec", msec, 0);
        check("loadrs_stays_running", running, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_dp.md
# stopwatch_dp

Time-keeping datapath and control for the stopwatch/watch display path. It divides the system clock down to a 100 Hz tick and runs cascaded msec/sec/min/hour counters under a STOP/RUN/CLEAR state machine. It also accepts a time-set load. It sits directly upstream of the FND controller, whose `msec`/`sec`/`min`/`hour` inputs are driven straight from this block's outputs.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 100: counting rate of the hundredths counter. Divider period N = CLK_FREQ/TICK_HZ. N must be an integer ≥ 1.

Ports:
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `run_stop` in 1: single-cycle pulse from the debounced button. Toggles RUN/STOP.
- `clear` in 1: single-cycle pulse. Zeros time, honoured only in STOP.
- `load` in 1: single-cycle pulse. Loads `set_*`, honoured only in STOP.
- `set_sec` in 6: load value, 0–59.
- `set_min` in 6: load value, 0–59.
- `set_hour` in 5: load value, 0–23.
- `msec` out 7: hundredths, 0–99.
- `sec` out 6: seconds, 0–59.
- `min` out 6: minutes, 0–59.
- `hour` out 5: hours, 0–23.
- `running` out 1: 1 while the FSM is in RUN.
- `tick` out 1: one-cycle pulse on each counting edge. This is the cycle in which the divider is N-1 and the state is RUN.

## Operation
- The FSM has three states, STOP, RUN and CLEAR, and is encoded in registers.
- Transitions out of STOP, in priority order:
  - `clear` → CLEAR.
  - `load` → STOP (load is applied).
  - `run_stop` → RUN.
  - Otherwise stay in STOP.
- Transitions out of RUN:
  - `run_stop` → STOP.
  - `clear` and `load` are ignored.
- CLEAR always goes to STOP on the next edge. All inputs are ignored while in CLEAR.
- Divider (0..N-1):
  - Advances only in cycles where the state is RUN.
  - At N-1 it wraps to 0 and asserts `tick`.
  - Holds its value in STOP, so a pause/resume preserves the fractional period.
- Counter cascade on `tick`:
  - msec increments.
  - msec 99 → 0 and sec increments.
  - sec 59 → 0 and min increments.
  - min 59 → 0 and hour increments.
  - hour 23 → 0 (full wrap to 00:00:00.00).
  - All carries resolve on the same edge.
- CLEAR state: on the edge leaving CLEAR, msec, sec, min, hour and the divider all become 0.
- Load (accepted in STOP):
  - On the sampling edge, sec/min/hour take the `set_*` values and msec and the divider become 0.
  - If any `set_*` field is out of range, the entire load is ignored and nothing changes.
- `running` and `tick` are decoded from registered state and divider. They contain no combinational path from inputs.

## Timing
- Reset (asynchronous, immediate): the state is STOP and every output is 0 (`msec`, `sec`, `min`, `hour`, `running`, `tick`). The divider is also 0.
- Reset mid-RUN or mid-CLEAR aborts immediately to the same reset values.
- `run_stop` sampled at edge k in STOP:
  - `running` = 1 after edge k.
  - With the divider at d, the first `tick` is in the cycle before edge k+(N-d), and msec changes at that edge.
- `run_stop` sampled at edge j in RUN:
  - The divider still advances at edge j, because the state is RUN in that cycle.
  - `running` = 0 after edge j. No further changes occur.
- `clear` sampled at edge k in STOP: the state is CLEAR after edge k, and outputs are zero and the state is STOP after edge k+1. Latency is 2 edges from the pulse.
- `load` sampled at edge k in STOP: the new values are visible after edge k (1 edge).
- Simultaneous inputs in STOP: `clear` with `load` or `run_stop` → only clear acts. `load` with `run_stop` → only load acts, and the state remains STOP.
- Pulses held longer than one cycle: each sampled cycle acts as a separate pulse. Debouncing is the upstream block's job.
- Outputs are stable between ticks and therefore safe to sample asynchronously in the FND scan domain.

## Test plan
All scenarios use CLK_FREQ=1000 and TICK_HZ=100, giving N=10.

1. Reset → all outputs 0 and `running`=0. Assert `reset` mid-RUN at 00:00:03.07 → immediately all 0 and `running`=0.
2. `run_stop` pulse, then 10 clocks → `msec`=1 with exactly one `tick` pulse. After 1000 RUN clocks → `msec`=0, `sec`=1.
3. Run 25 clocks (→ `msec`=2), stop, idle 100 clocks → `msec` stays 2. Resume and run 5 clocks → `msec`=3, confirming the divider is preserved.
4. `clear` during RUN at `msec`=4 → ignored and counting continues. Stop, then pulse `clear` → all zero exactly 2 edges later and state STOP. Pulse `clear` and `run_stop` together in STOP → clears and stays stopped.
5. In STOP, `load` with sec=59, min=59, hour=23 → 23:59:59.00 after 1 edge. Run 1000 clocks → 00:00:00.00, exercising the full wrap.
6. In STOP, `load` with set_min=60 → no change. `load` in RUN → ignored. `load` together with `run_stop` in STOP → loads and `running` stays 0.
